// File: rtl/lock_pkg.sv
// Shared types and defaults for the key-input loader that feeds key-locked netlists.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PARITY = 2'd2,
    CHECK  = 2'd3
  } lock_state_e;

  localparam int         KEY_W_DEF     = 8;
  localparam logic [7:0] DECOY_KEY_DEF = 8'hA5;

  // Counter must be able to hold 0..KEY_W.
  function automatic int cnt_w(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/lock_key_shift.sv
// Indexed shadow register plus running even-parity accumulator for one key frame.
module lock_key_shift
  import lock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CW    = cnt_w(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             first_i,
  input  logic             par_i,
  input  logic [CW-1:0]    idx_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             par_o
);

  logic [KEY_W-1:0] shadow_d, shadow_q;
  logic             par_d, par_q;

  always_comb begin
    shadow_d = shadow_q;
    par_d    = par_q;
    if (clr_i) begin
      shadow_d = '0;
      par_d    = 1'b0;
    end else begin
      for (int i = 0; i < KEY_W; i++)
        if (load_i && idx_i == CW'(i)) shadow_d[i] = bit_i;
      // First beat restarts the accumulator instead of folding into a stale value.
      if (first_i)                par_d = bit_i;
      else if (load_i || par_i)   par_d = par_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      par_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      par_q    <= par_d;
    end
  end

  assign shadow_o = shadow_q;
  assign par_o    = par_q;

endmodule

// File: rtl/lock_key_loader.sv
// Bit-serial key receiver: gathers KEY_W bits + parity, commits only parity-good keys to key_o.
module lock_key_loader
  import lock_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] DECOY_KEY = KEY_W'(DECOY_KEY_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_data,
  input  logic             clear_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             err,
  output logic             busy
);

  localparam int CW = cnt_w(KEY_W);

  lock_state_e      state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [KEY_W-1:0] key_d, key_q;
  logic             key_valid_d, key_valid_q;
  logic             err_d, err_q;
  logic             ready_d, ready_q;
  logic             busy_d, busy_q;

  logic             sh_clr, sh_load, sh_first, sh_par;
  logic [CW-1:0]    sh_idx;
  logic [KEY_W-1:0] shadow;
  logic             par;
  logic             accept;

  assign accept = s_valid && ready_q;

  lock_key_shift #(.KEY_W(KEY_W), .CW(CW)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (sh_clr),
    .load_i   (sh_load),
    .first_i  (sh_first),
    .par_i    (sh_par),
    .idx_i    (sh_idx),
    .bit_i    (s_data),
    .shadow_o (shadow),
    .par_o    (par)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    sh_clr      = 1'b0;
    sh_load     = 1'b0;
    sh_first    = 1'b0;
    sh_par      = 1'b0;
    sh_idx      = cnt_q;
    if (clear_i) begin
      // Beats in this cycle are handshaken but dropped; a CHECK commit loses too.
      state_d     = IDLE;
      cnt_d       = '0;
      key_d       = DECOY_KEY;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
      sh_clr      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          sh_load  = 1'b1;
          sh_first = 1'b1;
          sh_idx   = '0;
          cnt_d    = CW'(1);
          state_d  = (KEY_W == 1) ? PARITY : LOAD;
        end
        LOAD: if (accept) begin
          sh_load = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(KEY_W - 1)) state_d = PARITY;
        end
        PARITY: if (accept) begin
          sh_par  = 1'b1;
          state_d = CHECK;
        end
        CHECK: begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!par) begin
            key_d       = shadow;
            key_valid_d = 1'b1;
            err_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d != CHECK);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_q       <= DECOY_KEY;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign s_ready   = ready_q;
  assign key_o     = key_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: frame table plus clear / async-reset sequences.
module tb_lock_key_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_data = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] key_o;
  logic       key_valid;
  logic       err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lock_key_loader #(.KEY_W(8), .DECOY_KEY(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .clear_i   (clear_i),
    .key_o     (key_o),
    .key_valid (key_valid),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] key;
    logic       parbit;
    int         gapmax;
    logic [7:0] exp_key;
    logic       exp_kv;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one bit; returns #1 after the edge that accepted it.
  task automatic beat(input logic b);
    int n = 0;
    while (!s_ready && n < 20) begin tick(); n++; end
    check("ready_timeout", 64'(n >= 20), 64'd0);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  // Send a full frame; checks key_o is held until the commit edge and s_ready drops in CHECK.
  task automatic frame(input logic [7:0] k, input logic p, input int gapmax,
                       input logic [7:0] prev_key);
    for (int i = 0; i < 8; i++) begin
      beat(k[i]);
      check("key_held_mid_frame", 64'(key_o), 64'(prev_key));
      check("busy_mid_frame", 64'(busy), 64'd1);
      if (gapmax > 0) begin
        int g = $urandom_range(gapmax, 0);
        for (int j = 0; j < g; j++) tick();
      end
    end
    beat(p);
    check("ready_low_in_check", 64'(s_ready), 64'd0);
    check("key_held_in_check", 64'(key_o), 64'(prev_key));
    tick();
    check("ready_back_after_check", 64'(s_ready), 64'd1);
    check("busy_after_check", 64'(busy), 64'd0);
  endtask

  vec_t vecs[7];
  logic [7:0] cur_key;

  initial begin
    vecs[0] = '{8'h3C, 1'b0, 0, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 0, 8'h3C, 1'b1, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 0, 8'h81, 1'b1, 1'b0};
    vecs[3] = '{8'hF0, 1'b0, 5, 8'hF0, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 2, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 0, 8'h01, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 3, 8'h00, 1'b1, 1'b0};

    #12 rst = 1'b0;
    tick();
    check("rst_key", 64'(key_o), 64'hA5);
    check("rst_kv", 64'(key_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);

    cur_key = 8'hA5;
    foreach (vecs[i]) begin
      frame(vecs[i].key, vecs[i].parbit, vecs[i].gapmax, cur_key);
      check("vec_key", 64'(key_o), 64'(vecs[i].exp_key));
      check("vec_kv", 64'(key_valid), 64'(vecs[i].exp_kv));
      check("vec_err", 64'(err), 64'(vecs[i].exp_err));
      cur_key = vecs[i].exp_key;
    end

    // Clear after four bits of a frame.
    beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_key", 64'(key_o), 64'hA5);
    check("clr_kv", 64'(key_valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    frame(8'h3C, 1'b0, 0, 8'hA5);
    check("post_clr_key", 64'(key_o), 64'h3C);
    check("post_clr_kv", 64'(key_valid), 64'd1);

    // Clear landing in the CHECK cycle beats the commit.
    for (int i = 0; i < 8; i++) beat(1'(8'h81 >> i));
    beat(1'b0);
    check("chk_ready_low", 64'(s_ready), 64'd0);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_in_check_key", 64'(key_o), 64'hA5);
    check("clr_in_check_kv", 64'(key_valid), 64'd0);
    check("clr_in_check_busy", 64'(busy), 64'd0);

    // Async reset between edges, mid-LOAD, after a committed key.
    frame(8'h3C, 1'b1 ^ 1'b1, 0, 8'hA5);
    check("pre_rst_kv", 64'(key_valid), 64'd1);
    beat(1'b1); beat(1'b1); beat(1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_key", 64'(key_o), 64'hA5);
    check("async_rst_kv", 64'(key_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_ready", 64'(s_ready), 64'd1);
    check("async_rst_err", 64'(err), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    frame(8'h5A, 1'b0, 1, 8'hA5);
    check("post_rst_key", 64'(key_o), 64'h5A);
    check("post_rst_kv", 64'(key_valid), 64'd1);
    check("post_rst_err", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
